// File: rtl/cheat_pkg.sv
// rtl/cheat_pkg.sv - shared types and code_word field layout for the cheat engine
package cheat_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  typedef struct packed {
    logic en;
    logic cmp_en;
  } slot_flags_t;

  // code_word is {en, cmp_en, addr, cmp, rep} MSB first; rep sits at bit 0
  function automatic int cw_width(int aw, int dw);
    return 2 + aw + 2 * dw;
  endfunction

  function automatic int cmp_lsb(int dw);
    return dw;
  endfunction

  function automatic int addr_lsb(int dw);
    return 2 * dw;
  endfunction

  function automatic int cmpen_bit(int aw, int dw);
    return 2 * dw + aw;
  endfunction

  function automatic int en_bit(int aw, int dw);
    return 2 * dw + aw + 1;
  endfunction

  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cheat_slot.sv
// rtl/cheat_slot.sv - one code slot register with its address/data match comparator
module cheat_slot
  import cheat_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     wr_i,
  input  logic                                     clr_i,
  input  logic [cw_width(ADDR_W, DATA_W)-1:0]      word_i,
  input  logic [ADDR_W-1:0]                        addr_in_i,
  input  logic [DATA_W-1:0]                        data_in_i,
  input  logic                                     qual_i,
  output logic                                     match_o,
  output logic [DATA_W-1:0]                        rep_o
);

  localparam int A_LSB = addr_lsb(DATA_W);
  localparam int C_LSB = cmp_lsb(DATA_W);
  localparam int CE_B  = cmpen_bit(ADDR_W, DATA_W);
  localparam int EN_B  = en_bit(ADDR_W, DATA_W);

  slot_flags_t        flags_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  cmp_q;
  logic [DATA_W-1:0]  rep_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset || clr_i) begin
      flags_q <= '0;
      addr_q  <= '0;
      cmp_q   <= '0;
      rep_q   <= '0;
    end else if (wr_i) begin
      flags_q <= '{en: word_i[EN_B], cmp_en: word_i[CE_B]};
      addr_q  <= word_i[A_LSB +: ADDR_W];
      cmp_q   <= word_i[C_LSB +: DATA_W];
      rep_q   <= word_i[DATA_W-1:0];
    end
  end

  // A non-zero cmp field implies a data compare even when cmp_en is clear
  logic need_cmp;
  assign need_cmp = flags_q.cmp_en || (cmp_q != '0);

  assign match_o = qual_i && flags_q.en && (addr_q == addr_in_i) &&
                   (!need_cmp || (data_in_i == cmp_q));
  assign rep_o   = rep_q;

endmodule

// File: rtl/cheat_engine.sv
// rtl/cheat_engine.sv - cheat/code-override engine; optional CHEAT_HIT_COUNT_EN adds per-slot hit counters
module cheat_engine
  import cheat_pkg::*;
#(
  parameter int NUM_CODES = 32,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int REG_OUT   = 0
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   enable,
  input  logic [$clog2(NUM_CODES+1)-1:0]         slot_limit,
  input  logic                                   clear,
  output logic                                   busy,
  input  logic                                   code_valid,
  output logic                                   code_ready,
  input  logic [idx_w(NUM_CODES)-1:0]            code_slot,
  input  logic [cw_width(ADDR_W, DATA_W)-1:0]    code_word,
  input  logic [ADDR_W-1:0]                      addr_in,
  input  logic [DATA_W-1:0]                      data_in,
  input  logic                                   bus_ce,
  output logic                                   genie_ovr,
  output logic [DATA_W-1:0]                      genie_data,
  output logic [idx_w(NUM_CODES)-1:0]            hit_slot
`ifdef CHEAT_HIT_COUNT_EN
  ,
  input  logic [idx_w(NUM_CODES)-1:0]            hit_sel,
  output logic [15:0]                            hit_count
`endif
);

  localparam int IW = idx_w(NUM_CODES);
  localparam int SW = $clog2(NUM_CODES + 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   sweep_q, sweep_d;
  logic            xfer;

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    case (state_q)
      ST_IDLE: if (clear) begin
        state_d = ST_CLEAR;
        sweep_d = '0;
      end
      ST_CLEAR: begin
        if (clear) sweep_d = '0;
        else if (sweep_q == IW'(NUM_CODES - 1)) state_d = ST_IDLE;
        else sweep_d = sweep_q + IW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  assign busy       = (state_q == ST_CLEAR);
  assign code_ready = reset && (state_q == ST_IDLE) && !clear;
  assign xfer       = code_valid && code_ready;

  logic [NUM_CODES-1:0] match, wr_vec, clr_vec;
  logic [DATA_W-1:0]    rep_arr [NUM_CODES];

  // Out-of-range code_slot decodes to no slot, so the word is silently dropped
  for (genvar i = 0; i < NUM_CODES; i++) begin : g_slot
    localparam logic [SW-1:0] IDX_L = SW'(i);
    assign wr_vec[i]  = xfer && (code_slot == IW'(i));
    assign clr_vec[i] = busy && (sweep_q == IW'(i));
    cheat_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot (
      .clk       (clk),
      .reset     (reset),
      .wr_i      (wr_vec[i]),
      .clr_i     (clr_vec[i]),
      .word_i    (code_word),
      .addr_in_i (addr_in),
      .data_in_i (data_in),
      .qual_i    (enable && bus_ce && (slot_limit > IDX_L)),
      .match_o   (match[i]),
      .rep_o     (rep_arr[i])
    );
  end

  logic              win_ovr;
  logic [IW-1:0]     win_idx;
  logic [DATA_W-1:0] win_data;

  always_comb begin
    win_ovr  = 1'b0;
    win_idx  = '0;
    win_data = '0;
    for (int i = NUM_CODES - 1; i >= 0; i--) begin
      if (match[i]) begin
        win_ovr  = 1'b1;
        win_idx  = IW'(i);
        win_data = rep_arr[i];
      end
    end
  end

  if (REG_OUT != 0) begin : g_reg
    logic              ovr_q;
    logic [IW-1:0]     idx_q;
    logic [DATA_W-1:0] data_q;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        ovr_q  <= 1'b0;
        idx_q  <= '0;
        data_q <= '0;
      end else if (bus_ce) begin
        ovr_q  <= win_ovr;
        idx_q  <= win_idx;
        data_q <= win_data;
      end
    end
    assign genie_ovr  = ovr_q;
    assign genie_data = data_q;
    assign hit_slot   = idx_q;
  end else begin : g_comb
    assign genie_ovr  = win_ovr;
    assign genie_data = win_data;
    assign hit_slot   = win_idx;
  end

`ifdef CHEAT_HIT_COUNT_EN
  logic [15:0] cnt_q [NUM_CODES];

  // Sweep or reload of a slot restarts its count and beats a same-cycle hit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CODES; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CODES; i++) begin
        if (clr_vec[i] || wr_vec[i]) cnt_q[i] <= '0;
        else if (win_ovr && (win_idx == IW'(i)) && (cnt_q[i] != 16'hFFFF))
          cnt_q[i] <= cnt_q[i] + 16'd1;
      end
    end
  end

  assign hit_count = (int'(hit_sel) < NUM_CODES) ? cnt_q[hit_sel] : 16'd0;
`endif

endmodule

// File: tb/tb_cheat_engine.sv
// tb/tb_cheat_engine.sv - scoreboard bench for cheat_engine, combinational and registered builds
module tb_cheat_engine;

  localparam int N  = 32;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int SW = 6;
  localparam int IW = 5;
  localparam int CW = 2 + AW + 2 * DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b0, enable = 1'b1, clear = 1'b0, code_valid = 1'b0, bus_ce = 1'b0;
  logic [SW-1:0] slot_limit = 6'd32;
  logic [IW-1:0] code_slot = '0;
  logic [CW-1:0] code_word = '0;
  logic [AW-1:0] addr_in = '0;
  logic [DW-1:0] data_in = '0;

  logic          busy0, ready0, ovr0, busy1, ready1, ovr1;
  logic [DW-1:0] data0, data1;
  logic [IW-1:0] slot0, slot1;
`ifdef CHEAT_HIT_COUNT_EN
  logic [IW-1:0] hit_sel = '0;
  logic [15:0]   hcnt0, hcnt1;
`endif

  cheat_engine #(.NUM_CODES(N), .ADDR_W(AW), .DATA_W(DW), .REG_OUT(0)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .slot_limit(slot_limit), .clear(clear),
    .busy(busy0), .code_valid(code_valid), .code_ready(ready0), .code_slot(code_slot),
    .code_word(code_word), .addr_in(addr_in), .data_in(data_in), .bus_ce(bus_ce),
    .genie_ovr(ovr0), .genie_data(data0), .hit_slot(slot0)
`ifdef CHEAT_HIT_COUNT_EN
    , .hit_sel(hit_sel), .hit_count(hcnt0)
`endif
  );

  cheat_engine #(.NUM_CODES(N), .ADDR_W(AW), .DATA_W(DW), .REG_OUT(1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .slot_limit(slot_limit), .clear(clear),
    .busy(busy1), .code_valid(code_valid), .code_ready(ready1), .code_slot(code_slot),
    .code_word(code_word), .addr_in(addr_in), .data_in(data_in), .bus_ce(bus_ce),
    .genie_ovr(ovr1), .genie_data(data1), .hit_slot(slot1)
`ifdef CHEAT_HIT_COUNT_EN
    , .hit_sel(hit_sel), .hit_count(hcnt1)
`endif
  );

  typedef struct {
    int ovr; int data; int slot; int busy; int ready; int cnt;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t held;
  int   checks = 0;
  int   failures = 0;
  logic cap_ce = 1'b0;

  // Reference model: the slot table as plain arrays plus the number of sweep cycles left
  int m_en[N], m_ce[N], m_addr[N], m_cmp[N], m_rep[N], m_cnt[N];
  int busy_left;

  function automatic void zero_slot(int i);
    m_en[i] = 0; m_ce[i] = 0; m_addr[i] = 0; m_cmp[i] = 0; m_rep[i] = 0; m_cnt[i] = 0;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) zero_slot(i);
    busy_left = 0;
  endfunction

  function automatic exp_t predict();
    exp_t e;
    int   lim;
    e = '{default: 0};
    e.busy  = (reset && busy_left > 0) ? 1 : 0;
    e.ready = (reset && busy_left == 0 && !clear) ? 1 : 0;
`ifdef CHEAT_HIT_COUNT_EN
    e.cnt = m_cnt[hit_sel];
`endif
    if (!reset || !enable || !bus_ce) return e;
    lim = (int'(slot_limit) > N) ? N : int'(slot_limit);
    for (int i = 0; i < lim; i++) begin
      if (m_en[i] == 1 && m_addr[i] == int'(addr_in) &&
          ((m_ce[i] == 0 && m_cmp[i] == 0) || m_cmp[i] == int'(data_in))) begin
        e.ovr = 1; e.data = m_rep[i]; e.slot = i;
        return e;
      end
    end
    return e;
  endfunction

  task automatic step();
    exp_t e;
    if (!reset) model_reset();
    e = predict();
    q0.push_back(e);
    if (reset && bus_ce) q1.push_back(e);
    @(posedge clk);
    if (reset) begin
      if (e.ovr == 1 && m_cnt[e.slot] < 65535) m_cnt[e.slot]++;
      if (busy_left > 0) begin
        zero_slot(N - busy_left);
        busy_left = clear ? N : busy_left - 1;
      end else if (clear) begin
        busy_left = N;
      end else if (code_valid) begin
        m_en[code_slot]   = int'(code_word[CW-1]);
        m_ce[code_slot]   = int'(code_word[CW-2]);
        m_addr[code_slot] = int'(code_word[2*DW +: AW]);
        m_cmp[code_slot]  = int'(code_word[DW +: DW]);
        m_rep[code_slot]  = int'(code_word[DW-1:0]);
        m_cnt[code_slot]  = 0;
      end
    end
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp_v, $time);
    end
  endtask

  always @(posedge clk) cap_ce <= bus_ce && reset;

  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("busy",        int'(busy0),  e.busy);
      chk("code_ready",  int'(ready0), e.ready);
      chk("genie_ovr",   int'(ovr0),   e.ovr);
      chk("genie_data",  int'(data0),  e.data);
      chk("hit_slot",    int'(slot0),  e.slot);
      chk("busy_r",      int'(busy1),  e.busy);
`ifdef CHEAT_HIT_COUNT_EN
      chk("hit_count",   int'(hcnt0),  e.cnt);
      chk("hit_count_r", int'(hcnt1),  e.cnt);
`endif
      if (!reset) begin
        q1.delete();
        held = '{default: 0};
      end else if (cap_ce) begin
        if (q1.size() > 0) held = q1.pop_front();
        else chk("reg_queue_underflow", 1, 0);
      end
      chk("genie_ovr_r",  int'(ovr1),  held.ovr);
      chk("genie_data_r", int'(data1), held.data);
      chk("hit_slot_r",   int'(slot1), held.slot);
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load(input int slot, input logic en, input logic ce,
                      input logic [AW-1:0] a, input logic [DW-1:0] c, input logic [DW-1:0] r);
    code_valid = 1'b1;
    code_slot  = IW'(slot);
    code_word  = {en, ce, a, c, r};
    step();
    code_valid = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus_ce = 1'b1; addr_in = a; data_in = d;
    step();
    bus_ce = 1'b0;
  endtask

  logic [AW-1:0] pool [6];

  initial begin
    held = '{default: 0};
    model_reset();
    pool[0] = 16'h8123; pool[1] = 16'hC000; pool[2] = 16'h9000;
    pool[3] = 16'hD000; pool[4] = 16'hA000; pool[5] = 16'hA001;
    @(posedge clk); #1;
    idle(3);
    reset = 1'b1;
    idle(1);

    load(0, 1'b1, 1'b0, 16'h8123, 8'h00, 8'hEA);
    rd(16'h8123, 8'h55);
    load(2, 1'b1, 1'b1, 16'hC000, 8'h3C, 8'h00);
    rd(16'hC000, 8'h3C);
    rd(16'hC000, 8'h3D);
    load(1, 1'b1, 1'b0, 16'h9000, 8'h00, 8'h11);
    load(5, 1'b1, 1'b0, 16'h9000, 8'h00, 8'h22);
    rd(16'h9000, 8'h00);
    slot_limit = 6'd1;
    rd(16'h9000, 8'h00);
    slot_limit = 6'd63;
    rd(16'h9000, 8'h00);
    slot_limit = 6'd32;

    // registered output must hold across idle bus cycles
    idle(3);
    rd(16'h8123, 8'h00);
    idle(3);

`ifdef CHEAT_HIT_COUNT_EN
    hit_sel = 5'd4;
    load(4, 1'b1, 1'b0, 16'hD000, 8'h00, 8'h44);
    for (int i = 0; i < 3; i++) rd(16'hD000, 8'h12);
    idle(2);
`endif

    for (int i = 0; i < N; i++) load(i, 1'b1, 1'b0, 16'hA000 + AW'(i), 8'h00, DW'(i + 1));
    clear = 1'b1; step(); clear = 1'b0;
    for (int i = 0; i < 10; i++) rd(16'hA000 + AW'(i * 3), 8'h00);
    clear = 1'b1; step(); clear = 1'b0;
    for (int i = 0; i < N + 4; i++) rd(16'hA000 + AW'(i), 8'h00);

    load(3, 1'b1, 1'b0, 16'hB000, 8'h00, 8'h33);
    code_valid = 1'b1; clear = 1'b1; code_slot = 5'd7;
    code_word = {1'b1, 1'b0, 16'hB100, 8'h00, 8'h77};
    step();
    code_valid = 1'b0; clear = 1'b0;
    rd(16'hB000, 8'h00);
    idle(N + 2);

    load(9, 1'b1, 1'b0, 16'hE000, 8'h00, 8'h99);
    clear = 1'b1; step(); clear = 1'b0;
    idle(5);
    reset = 1'b0; step();
    reset = 1'b1;
    rd(16'hE000, 8'h00);
    rd(16'hA010, 8'h00);

    for (int k = 0; k < 1500; k++) begin
      clear      = ($urandom_range(0, 99) < 3);
      code_valid = ($urandom_range(0, 99) < 25);
      code_slot  = IW'($urandom_range(0, N - 1));
      code_word  = {1'($urandom_range(0, 99) < 85), 1'($urandom_range(0, 1)),
                    pool[$urandom_range(0, 5)],
                    ($urandom_range(0, 1) == 1) ? 8'h00 : 8'h3C,
                    8'($urandom)};
      bus_ce     = ($urandom_range(0, 99) < 60);
      addr_in    = pool[$urandom_range(0, 5)];
      data_in    = ($urandom_range(0, 1) == 1) ? 8'h3C : 8'($urandom);
      enable     = ($urandom_range(0, 99) < 92);
      if ($urandom_range(0, 99) < 5) slot_limit = SW'($urandom_range(0, 63));
`ifdef CHEAT_HIT_COUNT_EN
      hit_sel    = IW'($urandom_range(0, N - 1));
`endif
      if ($urandom_range(0, 999) < 3) reset = 1'b0;
      step();
      reset = 1'b1;
    end
    clear = 1'b0; code_valid = 1'b0; bus_ce = 1'b0;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cheat_engine.md
Name: cheat_engine

Overview:
Parametrised cheat/code-override engine holding NUM_CODES address/compare/replace slots. Sits between the CPU read-data mux and the CPU and substitutes replacement data on matching reads. Slots are written through a valid/ready load port fed by any code-entry front end (ROM hijack, OSD menu, file loader). A sequential sweep clears all slots; optional per-slot hit counters are provided.

Parameters:
NUM_CODES, 32, number of code slots (1..64)
ADDR_W, 16, bus address width compared per slot
DATA_W, 8, bus data width (compare and replace fields)
REG_OUT, 0, 0 = combinational override; 1 = override registered, one-cycle latency

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
enable  in  1  global override enable
slot_limit  in  $clog2(NUM_CODES+1)  only slots with index < slot_limit may match
clear  in  1  pulse: start clear sweep
busy  out  1  clear sweep in progress
code_valid  in  1  load request
code_ready  out  1  load port can accept
code_slot  in  $clog2(NUM_CODES)  target slot
code_word  in  2+ADDR_W+2*DATA_W  {en, cmp_en, addr, cmp, rep}, MSB first
addr_in  in  ADDR_W  bus address
data_in  in  DATA_W  original bus read data
bus_ce  in  1  bus read strobe qualifier
genie_ovr  out  1  replace data this access
genie_data  out  DATA_W  replacement data
hit_slot  out  $clog2(NUM_CODES)  index of winning slot

Behaviour:
- Reset (async, low): all slots zeroed, FSM IDLE, busy=0, code_ready=0 while asserted, genie_ovr=0, genie_data=0, hit_slot=0.
- FSM states: IDLE, CLEAR. IDLE->CLEAR on clear=1. CLEAR writes zero to slot sweep_idx each cycle, 0..NUM_CODES-1, then IDLE. Sweep takes exactly NUM_CODES cycles. busy=1 in CLEAR.
- clear asserted during CLEAR: restart sweep at index 0.
- code_ready = IDLE & ~clear. Transfer occurs on code_valid & code_ready; slot written on that edge, visible to matching next cycle. clear and code_valid in the same cycle: clear wins, no transfer. code_slot >= NUM_CODES: transfer accepted, word dropped.
- Slot match: en=1 & addr==addr_in & index<slot_limit & enable & bus_ce. If cmp_en=1 or cmp!=0, data_in==cmp is also required; otherwise the slot matches unconditionally.
- Priority: the lowest matching index wins and drives genie_data=rep and hit_slot=index. With no match, genie_ovr=0, genie_data=0, hit_slot=0.
- REG_OUT=0: outputs combinational from current inputs. REG_OUT=1: outputs registered on the clk edge where bus_ce=1 and held until the next bus_ce.
- Slot writes in the same cycle as a match on that slot: the match uses the old contents.
- slot_limit > NUM_CODES is treated as NUM_CODES.

Optional Feature:
CHEAT_HIT_COUNT_EN:
- Defined: adds input hit_sel ($clog2(NUM_CODES)) and output hit_count (16 bits).
- Each slot has a 16-bit saturating counter that increments on every clk with bus_ce=1 where that slot wins (genie_ovr=1).
- Counters are zeroed by reset, by the clear sweep (per slot as swept), and by a load to that slot.
- hit_count = counter[hit_sel], combinational.
- Undefined: no ports, no counters.

Decomposition:
- Package cheat_pkg: code_word field offsets and widths as functions of ADDR_W/DATA_W, FSM state enum (IDLE, CLEAR), slot struct typedef.
- Sub-module cheat_slot: one slot register plus match comparator. Instantiated NUM_CODES times via generate; the top holds the FSM, load port, priority encoder and output stage.

Test Plan:
- Load slot 0 {en=1, cmp_en=0, addr=0x8123, rep=0xEA}; read 0x8123 with data 0x55, bus_ce=1 -> genie_ovr=1, genie_data=0xEA, hit_slot=0.
- Slot 2 {en=1, cmp_en=1, addr=0xC000, cmp=0x3C, rep=0x00}: read data 0x3C -> ovr=1, data 0x00; read data 0x3D -> ovr=0.
- Slots 1 and 5 both at 0x9000 with rep 0x11/0x22 -> genie_data=0x11, hit_slot=1; slot_limit=1 -> ovr=0.
- Fill all slots, pulse clear: busy=1 for exactly NUM_CODES cycles and code_ready=0 throughout. Pulse clear again mid-sweep -> sweep restarts. After the sweep, no address matches.
- Assert code_valid with clear in the same cycle -> no write. Deassert reset mid-sweep -> all slots zero, busy=0 immediately.
- REG_OUT=1: match on cycle N -> genie_ovr rises at N+1 and holds until the next bus_ce. With CHEAT_HIT_COUNT_EN defined, 3 hits on slot 4 -> hit_count=3 at hit_sel=4.
